fp_decoder: RTL and testbench

Sequential decoder from the 8-bit floating-point format (1 sign, 3 exponent, 4 significand bits) back to a 12-bit two's-complement linear value. It is the inverse path of the linear-to-float converter. It takes one packed float word through a valid/ready input handshake, rebuilds the magnitude with an iterative left shift, applies the sign, and holds the result on a valid/ready output handshake. It sits between the float storage/display path and any consumer that needs linear samples.

---
 rtl/fp_pkg.sv | 24 ++
 rtl/fp_mag_shifter.sv | 77 +++++++
 rtl/fp_decoder.sv | 97 +++++++++
 tb/tb_fp_decoder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the 8-bit float (1/3/4) to linear decoder:
// default field widths, packed-word field positions and the FSM state type.
package fp_pkg;

    localparam int unsigned EXP_W_DEF = 3;
    localparam int unsigned SIG_W_DEF = 4;
    localparam int unsigned LIN_W_DEF = 12;

    localparam int unsigned FP_W_DEF  = 1 + EXP_W_DEF + SIG_W_DEF;

    // Packed float layout {sign, exp, sig}, sign in the MSB
    localparam int unsigned SIGN_IDX  = FP_W_DEF - 1;
    localparam int unsigned EXP_HI    = FP_W_DEF - 2;
    localparam int unsigned EXP_LO    = SIG_W_DEF;
    localparam int unsigned SIG_HI    = SIG_W_DEF - 1;
    localparam int unsigned SIG_LO    = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/fp_mag_shifter.sv
// Magnitude rebuild for the float decoder: mag = sig << exp.
// FP_DECODER_BARREL_EN selects a one-step barrel shift instead of the iterative shifter.
module fp_mag_shifter
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEF,
    parameter int unsigned SIG_W = SIG_W_DEF,
    parameter int unsigned LIN_W = LIN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [SIG_W-1:0] sig_i,
    input  logic [EXP_W-1:0] exp_i,
    output logic [LIN_W-1:0] mag_o,
    output logic             done_o
);

    logic [LIN_W-1:0] mag_q, mag_d;

`ifdef FP_DECODER_BARREL_EN

    // Whole shift happens at load, so the first SHIFT cycle already sees the result
    always_comb begin
        mag_d = mag_q;
        if (load_i) begin
            mag_d = LIN_W'(sig_i) << exp_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q <= '0;
        end else begin
            mag_q <= mag_d;
        end
    end

    assign done_o = 1'b1;

    logic unused_shift;
    assign unused_shift = shift_i;

`else

    logic [EXP_W-1:0] cnt_q, cnt_d;

    always_comb begin
        mag_d = mag_q;
        cnt_d = cnt_q;
        if (load_i) begin
            mag_d = LIN_W'(sig_i);
            cnt_d = exp_i;
        end else if (shift_i && (cnt_q != '0)) begin
            mag_d = mag_q << 1;
            cnt_d = cnt_q - EXP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q <= '0;
            cnt_q <= '0;
        end else begin
            mag_q <= mag_d;
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

`endif

    assign mag_o = mag_q;

endmodule

// File: rtl/fp_decoder.sv
// Float (sign/exp/sig, no hidden one) to signed linear decoder with valid/ready
// on both sides; FP_DECODER_BARREL_EN in fp_mag_shifter trades latency for a barrel shift.
module fp_decoder
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEF,
    parameter int unsigned SIG_W = SIG_W_DEF,
    parameter int unsigned LIN_W = LIN_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+SIG_W:0]   in_fp,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LIN_W-1:0]       out_lin,
    output logic                   busy
);

    state_e           state_q, state_d;
    logic             sign_q;
    logic [LIN_W-1:0] out_lin_q, out_lin_d;
    logic [LIN_W-1:0] mag;
    logic             mag_done;
    logic             load;
    logic             shift_en;

    logic             fp_sign;
    logic [EXP_W-1:0] fp_exp;
    logic [SIG_W-1:0] fp_sig;

    assign fp_sign = in_fp[EXP_W+SIG_W];
    assign fp_exp  = in_fp[EXP_W+SIG_W-1 -: EXP_W];
    assign fp_sig  = in_fp[SIG_W-1:0];

    fp_mag_shifter #(
        .EXP_W (EXP_W),
        .SIG_W (SIG_W),
        .LIN_W (LIN_W)
    ) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .shift_i (shift_en),
        .sig_i   (fp_sig),
        .exp_i   (fp_exp),
        .mag_o   (mag),
        .done_o  (mag_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = SHIFT;
            SHIFT:   if (mag_done)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q == SHIFT) || (state_q == DONE);
        out_valid = (state_q == DONE);
        load      = (state_q == IDLE) && in_valid;
        shift_en  = (state_q == SHIFT);
    end

    // Negative zero falls out of two's negation of a zero magnitude
    assign out_lin_d = sign_q ? (-mag) : mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q    <= 1'b0;
            out_lin_q <= '0;
        end else begin
            if (load) begin
                sign_q <= fp_sign;
            end
            if (shift_en && mag_done) begin
                out_lin_q <= out_lin_d;
            end
        end
    end

    assign out_lin = out_lin_q;

endmodule

// File: tb/tb_fp_decoder.sv
// Self-checking bench for fp_decoder: vector table, backpressure, mid-shift reset
// and a random stream against a sign*sig*2^exp reference with a result queue.
module tb_fp_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_fp;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_lin;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [11:0] exp_q[$];

    typedef struct {
        logic [7:0]  fp;
        logic [11:0] lin;
    } vec_t;

    vec_t vecs[8];

    fp_decoder #(
        .EXP_W (3),
        .SIG_W (4),
        .LIN_W (12)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fp     (in_fp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_lin   (out_lin),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic int exp_lat(input logic [7:0] fp);
`ifdef FP_DECODER_BARREL_EN
        return 1;
`else
        return int'(fp[6:4]) + 1;
`endif
    endfunction

    function automatic logic [11:0] model(input logic [7:0] fp);
        int m;
        m = int'(fp[3:0]) << fp[6:4];
        if (fp[7]) m = -m;
        return 12'(m);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic pop_check(input string name);
        logic [11:0] w;
        if (exp_q.size() == 0) begin
            check({name, "_queue_nonempty"}, 0, 1);
        end else begin
            w = exp_q.pop_front();
            check(name, out_lin, w);
        end
    endtask

    task automatic send(input logic [7:0] fp);
        @(negedge clk);
        check("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        in_fp    = fp;
        exp_q.push_back(model(fp));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_fp    = 8'($urandom);
        check("busy_after_accept", busy, 1);
    endtask

    // Counts edges after accept until out_valid; flags in_ready rising while waiting
    task automatic wait_valid(output int cyc, output bit rdy_leak);
        cyc      = 0;
        rdy_leak = 1'b0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (in_ready) rdy_leak = 1'b1;
        end while (!out_valid && cyc < 20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  cyc;
        bit  leak;
        bit  flag;
        int  sent;
        int  got;
        int  spurious;
        logic [7:0] words[8];

        vecs[0] = '{8'b0_011_1010, 12'h050};
        vecs[1] = '{8'b1_111_1111, 12'h880};
        vecs[2] = '{8'b1_000_0000, 12'h000};
        vecs[3] = '{8'b1_101_0000, 12'h000};
        vecs[4] = '{8'b0_111_1111, 12'h780};
        vecs[5] = '{8'b1_000_0001, 12'hFFF};
        vecs[6] = '{8'b0_001_0001, 12'h002};
        vecs[7] = '{8'b1_010_0011, 12'hFF4};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_fp     = '0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_lin",   out_lin,   0);
        check("rst_busy",      busy,      0);
        rst_n = 1'b1;

        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_q.delete();
            @(negedge clk);
            check("tbl_in_ready_before_accept", in_ready, 1);
            in_valid = 1'b1;
            in_fp    = vecs[i].fp;
            exp_q.push_back(vecs[i].lin);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_fp    = 8'($urandom);
            wait_valid(cyc, leak);
            check("tbl_latency", cyc, exp_lat(vecs[i].fp));
            check("tbl_in_ready_low", leak, 0);
            check("tbl_busy_done", busy, 1);
            pop_check("tbl_out_lin");
            @(posedge clk);
            #1;
            check("tbl_in_ready_after_hs", in_ready, 1);
            check("tbl_out_valid_after_hs", out_valid, 0);
        end

        // Backpressure: result held, new words refused
        out_ready = 1'b0;
        send(8'b0_000_0101);
        wait_valid(cyc, leak);
        check("bp_latency", cyc, 1);
        flag = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (out_lin !== 12'h005 || !out_valid || !busy || in_ready) flag = 1'b1;
            in_valid = 1'b1;
            in_fp    = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_hold_stable", flag, 0);
        pop_check("bp_out_lin");
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        flag = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) flag = 1'b1;
        end
        check("bp_single_handshake", flag, 0);
        check("bp_queue_empty", exp_q.size(), 0);

        // Reset pulse mid-shift drops the in-flight word
        send(8'b0_110_1111);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_lin",   out_lin,   0);
        check("arst_in_ready",  in_ready,  1);
        check("arst_busy",      busy,      0);
        rst_n = 1'b1;
        exp_q.delete();
        send(8'b0_001_0001);
        wait_valid(cyc, leak);
        check("post_rst_latency", cyc, exp_lat(8'b0_001_0001));
        pop_check("post_rst_out_lin");
        @(posedge clk);
        #1;

        // Random stream with random consumer stall
        for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
        words[0] = 8'b1_111_0000;
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 8 && cyc < 600) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                pop_check("rnd_out_lin");
                got++;
            end
            if (in_ready && sent < 8) begin
                in_valid = 1'b1;
                in_fp    = words[sent];
                exp_q.push_back(model(words[sent]));
                sent++;
            end else begin
                in_valid = 1'b0;
                in_fp    = 8'($urandom);
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("rnd_received", got, 8);
        spurious = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        check("rnd_no_duplicates", spurious, 0);
        check("rnd_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
